// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM round-robin arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

   typedef logic mid_t;

   function automatic mid_t other_master(input mid_t m);
      return ~m;
   endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Master-ID tag FIFO recording the issue order of outstanding SDRAM reads.
module sdram_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  mid_t             push_tag,
   input  logic             pop,
   output mid_t             head_tag,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   mid_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign head_tag = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_tag;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller Avalon-MM slave;
// read returns are steered back to the issuing master through a tag FIFO.
module sdram_rr_arbiter
   import sdram_arb_pkg::*;
#(
   parameter  int unsigned ADDR_W      = 25,
   parameter  int unsigned DATA_W      = 32,
   parameter  int unsigned MAX_PENDING = 4,
   localparam int unsigned BE_W        = DATA_W / 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic [BE_W-1:0]   m0_byteenable,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [BE_W-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   output logic [BE_W-1:0]   s_byteenable,
   input  logic              s_waitrequest,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic              s_readdatavalid,
   output logic              err_orphan
);

   localparam int unsigned CNT_W = $clog2(MAX_PENDING) + 1;

   arb_state_t       state;
   mid_t             prio;
   mid_t             owner;
   mid_t             head_tag;
   logic             granted;
   logic             req0;
   logic             req1;
   logic             req_own;
   logic             req_oth;
   logic             sel_read;
   logic             sel_write;
   logic             rd_block;
   logic             accept;
   logic             push;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   always_comb begin
      owner        = mid_t'(state == OWN1);
      granted      = (state != IDLE);
      req_own      = owner ? req1 : req0;
      req_oth      = owner ? req0 : req1;
      sel_read     = owner ? m1_read : m0_read;
      sel_write    = owner ? m1_write : m0_write;
      s_address    = owner ? m1_address : m0_address;
      s_writedata  = owner ? m1_writedata : m0_writedata;
      s_byteenable = owner ? m1_byteenable : m0_byteenable;
      // A read with no free tag slot is held off the slave; writes are never blocked.
      rd_block     = granted & sel_read & (fifo_count == CNT_W'(MAX_PENDING));
      s_read       = granted & sel_read & ~rd_block;
      s_write      = granted & sel_write;
      accept       = (s_read | s_write) & ~s_waitrequest;
      push         = accept & s_read;
      m0_waitrequest = (state == OWN0) ? (s_waitrequest | rd_block) : 1'b1;
      m1_waitrequest = (state == OWN1) ? (s_waitrequest | rd_block) : 1'b1;
   end

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & (head_tag == 1'b0);
   assign m1_readdatavalid = s_readdatavalid & ~fifo_empty & (head_tag == 1'b1);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state      <= IDLE;
         prio       <= 1'b0;
         err_orphan <= 1'b0;
      end else begin
         if (s_readdatavalid && fifo_empty) err_orphan <= 1'b1;
         case (state)
            IDLE: begin
               if (req0 && (!req1 || prio == 1'b0)) state <= OWN0;
               else if (req1)                       state <= OWN1;
            end
            OWN0, OWN1: begin
               // Hand over directly to a waiting peer so alternating traffic has no bubble.
               if (accept) begin
                  prio  <= other_master(owner);
                  state <= req_oth ? (owner ? OWN0 : OWN1) : IDLE;
               end else if (!req_own) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sdram_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .push     (push),
      .push_tag (owner),
      .pop      (s_readdatavalid),
      .head_tag (head_tag),
      .count    (fifo_count),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Bench for sdram_rr_arbiter: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_sdram_rr_arbiter;

   localparam int unsigned ADDR_W      = 25;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned MAX_PENDING = 4;
   localparam int unsigned BE_W        = DATA_W / 8;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n;
   logic [ADDR_W-1:0] m0_address, m1_address, s_address;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
   logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
   logic              s_read, s_write, s_waitrequest, s_readdatavalid, err_orphan;
   logic [6:0]        ctl;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk_clk = ~clk_clk;

   sdram_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .err_orphan(err_orphan)
   );

   // {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_orphan}
   assign ctl = {s_read, s_write, m0_waitrequest, m1_waitrequest,
                 m0_readdatavalid, m1_readdatavalid, err_orphan};

   typedef struct {
      logic [5:0]  in;    // {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid}
      logic [31:0] rdata;
      logic [6:0]  exp;
      int          own;   // master whose command must appear on the slave, -1 if none
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input string nm, input logic [5:0] in, input logic [6:0] exp,
                      input logic [31:0] rdata, input int own);
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = in;
      s_readdata = rdata;
      @(negedge clk_clk);
      check(nm, 64'(ctl), 64'(exp));
      if (own >= 0) begin
         check({nm, "_addr"}, 64'(s_address), (own == 1) ? 64'h20 : 64'h10);
         if (exp[5])
            check({nm, "_wdata"}, 64'(s_writedata), (own == 1) ? 64'hCAFEF00D : 64'hDEADBEEF);
      end
      if (exp[2]) check({nm, "_rd0"}, 64'(m0_readdata), 64'(rdata));
      if (exp[1]) check({nm, "_rd1"}, 64'(m1_readdata), 64'(rdata));
      @(posedge clk_clk);
      #1;
   endtask

   task automatic hc(input string nm, input logic [5:0] in, input logic [6:0] exp);
      cyc(nm, in, exp, $urandom(), -1);
   endtask

   task automatic do_reset();
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = '0;
      reset_reset_n = 1'b0;
      repeat (2) @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
   endtask

   task automatic run_random(input int unsigned ncyc);
      int   own  = -1;
      int   prio = 0;
      int   q[$];
      bit   mrd[2], mwr[2], req[2];
      logic [ADDR_W-1:0] ma[2];
      logic [DATA_W-1:0] md[2];
      logic [BE_W-1:0]   mb[2];
      bit   sw, rv, grant, blk, e_rd, e_wr, e_w0, e_w1, e_v0, e_v1, acc;
      logic [DATA_W-1:0] rd;
      int   o;
      mrd = '{0, 0}; mwr = '{0, 0};
      for (int unsigned cy = 0; cy < ncyc; cy++) begin
         for (int n = 0; n < 2; n++) begin
            if (!mrd[n] && !mwr[n]) begin
               if ($urandom_range(0, 2) == 0) begin
                  if ($urandom_range(0, 1) == 0) mrd[n] = 1'b1; else mwr[n] = 1'b1;
                  ma[n] = ADDR_W'($urandom());
                  md[n] = $urandom();
                  mb[n] = BE_W'($urandom());
               end
            end else if ($urandom_range(0, 29) == 0) begin
               mrd[n] = 1'b0; mwr[n] = 1'b0;
            end
         end
         sw = ($urandom_range(0, 3) == 0);
         rv = (q.size() > 0) && ($urandom_range(0, 3) == 0);
         rd = $urandom();
         m0_read = mrd[0]; m0_write = mwr[0]; m0_address = ma[0]; m0_writedata = md[0]; m0_byteenable = mb[0];
         m1_read = mrd[1]; m1_write = mwr[1]; m1_address = ma[1]; m1_writedata = md[1]; m1_byteenable = mb[1];
         s_waitrequest = sw; s_readdatavalid = rv; s_readdata = rd;
         @(negedge clk_clk);
         grant = (own >= 0);
         blk   = grant && mrd[own] && (q.size() == MAX_PENDING);
         e_rd  = grant && mrd[own] && !blk;
         e_wr  = grant && mwr[own];
         e_w0  = (own == 0) ? (sw || blk) : 1'b1;
         e_w1  = (own == 1) ? (sw || blk) : 1'b1;
         e_v0  = rv && (q.size() > 0) && (q[0] == 0);
         e_v1  = rv && (q.size() > 0) && (q[0] == 1);
         check("rnd_ctl", 64'(ctl), 64'({e_rd, e_wr, e_w0, e_w1, e_v0, e_v1, 1'b0}));
         if (e_rd || e_wr)
            check("rnd_cmd", 64'({s_address, s_writedata, s_byteenable}), 64'({ma[own], md[own], mb[own]}));
         if (rv) check("rnd_rdata", 64'({m0_readdata, m1_readdata}), 64'({rd, rd}));
         acc = (e_rd || e_wr) && !sw;
         req[0] = mrd[0] || mwr[0];
         req[1] = mrd[1] || mwr[1];
         if (rv && q.size() > 0) void'(q.pop_front());
         if (acc && e_rd) q.push_back(own);
         o = own;
         if (own < 0) begin
            if (req[0] && (!req[1] || prio == 0)) own = 0;
            else if (req[1])                      own = 1;
         end else if (acc) begin
            prio = 1 - own;
            own  = req[1 - own] ? 1 - own : -1;
         end else if (!req[own]) begin
            own = -1;
         end
         if (acc) begin
            mrd[o] = 1'b0; mwr[o] = 1'b0;
         end
         @(posedge clk_clk);
         #1;
      end
   endtask

   initial begin
      vec_t tbl[$];
      m0_address = 25'h10; m1_address = 25'h20;
      m0_writedata = 32'hDEADBEEF; m1_writedata = 32'hCAFEF00D;
      m0_byteenable = '1; m1_byteenable = '1; s_readdata = '0;
      do_reset();

      // Reset state, simultaneous reads (M0 first, no bubble), in-order returns, single M0 write.
      tbl.push_back('{6'b000000, 32'h0,        7'b0011000, -1});
      tbl.push_back('{6'b101000, 32'h0,        7'b0011000, -1});
      tbl.push_back('{6'b101000, 32'h0,        7'b1001000,  0});
      tbl.push_back('{6'b001000, 32'h0,        7'b1010000,  1});
      tbl.push_back('{6'b000001, 32'h11111111, 7'b0011100, -1});
      tbl.push_back('{6'b000001, 32'h22222222, 7'b0011010, -1});
      tbl.push_back('{6'b010000, 32'h0,        7'b0011000, -1});
      tbl.push_back('{6'b010000, 32'h0,        7'b0101000,  0});
      tbl.push_back('{6'b000000, 32'h0,        7'b0011000, -1});
      foreach (tbl[i]) cyc($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp, tbl[i].rdata, tbl[i].own);

      // M1 issues five reads: four accepted, fifth held until a return frees a slot.
      for (int i = 0; i < 4; i++) begin
         hc("a_idle", 6'b001000, 7'b0011000);
         hc("a_acc",  6'b001000, 7'b1010000);
      end
      hc("a_idle5", 6'b001000, 7'b0011000);
      for (int i = 0; i < 3; i++) hc("a_blk", 6'b001000, 7'b0011000);
      hc("a_pop", 6'b001001, 7'b0011010);
      hc("a_5th", 6'b001000, 7'b1010000);

      // Full FIFO: M0 write still passes; push and pop together leave the count alone.
      hc("b_idle", 6'b011000, 7'b0011000);
      cyc("b_wr", 6'b011000, 7'b0101000, 32'h0, 0);
      hc("b_blk", 6'b001000, 7'b0011000);
      hc("b_pop", 6'b001001, 7'b0011010);
      hc("b_pushpop", 6'b001001, 7'b1010010);
      hc("b_idle2", 6'b001000, 7'b0011000);
      hc("b_acc4", 6'b001000, 7'b1010000);
      hc("b_idle3", 6'b001000, 7'b0011000);
      hc("b_full", 6'b001000, 7'b0011000);
      hc("b_drain0", 6'b000001, 7'b0010010);
      for (int i = 0; i < 3; i++) hc("b_drain", 6'b000001, 7'b0011010);

      // Slave stalls M0's read for 10 cycles while M1 waits; no tag pushed while stalled.
      hc("c_req", 6'b101010, 7'b0011000);
      for (int i = 0; i < 10; i++) hc("c_wait", 6'b101010, 7'b1011000);
      hc("c_acc", 6'b101000, 7'b1001000);
      hc("c_m1",  6'b001000, 7'b1010000);
      hc("c_r0",  6'b000001, 7'b0011100);
      hc("c_r1",  6'b000001, 7'b0011010);

      // Orphan return sets the sticky error.
      hc("d_orph",    6'b000001, 7'b0011000);
      hc("d_sticky",  6'b000000, 7'b0011001);
      hc("d_sticky2", 6'b000000, 7'b0011001);

      // Async reset while a read is in flight and another is on the slave.
      hc("e_req",  6'b100000, 7'b0011001);
      hc("e_acc",  6'b100000, 7'b1001001);
      hc("e_idle", 6'b100010, 7'b0011001);
      @(negedge clk_clk);
      check("e_own", 64'(ctl), 64'(7'b1011001));
      #1 reset_reset_n = 1'b0;
      #1 s_readdatavalid = 1'b1;
      #1 check("e_rst", 64'(ctl), 64'(7'b0011000));
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = '0;
      @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      hc("e_orph", 6'b000001, 7'b0011000);
      hc("e_err",  6'b000000, 7'b0011001);

      do_reset();
      run_random(3000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
